// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants, display mode enum and hex-to-segment table for 7-seg displays
package seg7_pkg;
  localparam logic [7:0] SEG_OFF = 8'hFF;
  typedef enum logic {MODE_TEXT = 1'b0, MODE_GFX = 1'b1} mode_e;
  function automatic logic [6:0] hex2seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction
endpackage

// File: rtl/seg7_hex_dec.sv
// seg7_hex_dec: combinational nibble to active-low {g..a} segment decoder
module seg7_hex_dec
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  always_comb seg = hex2seg(nib);
endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: double-buffered 8-digit common-anode 7-seg scanner with hex text and raw graphic modes
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int DIV_W     = 15,
  parameter int BLANK_CYC = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] i_data,
  input  logic        i_valid,
  input  logic        disp_mode,
  input  logic [7:0]  i_dp,
  input  logic        i_blank_lz,
  output logic [7:0]  o_seg,
  output logic [7:0]  o_sel,
  output logic        o_frame
);
  localparam logic [DIV_W-1:0] BLANK = DIV_W'(BLANK_CYC);
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [63:0]      pend_data_q, pend_data_d, act_data_q, act_data_d;
  mode_e            pend_mode_q, pend_mode_d, act_mode_q, act_mode_d;
  logic [7:0]       pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
  logic [7:0]       seg_q, seg_d, sel_q, sel_d;
  logic             frame_q, frame_d;
  logic             tick, boundary, blank, lz;
  logic [6:0]       hex_seg;
  seg7_hex_dec u_dec (
    .nib (act_data_q[{idx_q, 2'b00} +: 4]),
    .seg (hex_seg)
  );
  always_comb begin
    tick        = &cnt_q;
    boundary    = tick && (idx_q == 3'd7);
    blank       = cnt_q < BLANK;
    lz          = (idx_q != 3'd0) && ((act_data_q[31:0] >> {idx_q, 2'b00}) == 32'd0);
    cnt_d       = cnt_q + 1'b1;
    idx_d       = tick ? idx_q + 3'd1 : idx_q;
    pend_data_d = i_valid ? i_data : pend_data_q;
    pend_mode_d = i_valid ? mode_e'(disp_mode) : pend_mode_q;
    pend_dp_d   = i_valid ? i_dp : pend_dp_q;
    act_data_d  = boundary ? pend_data_d : act_data_q;
    act_mode_d  = boundary ? pend_mode_d : act_mode_q;
    act_dp_d    = boundary ? pend_dp_d : act_dp_q;
    frame_d     = boundary;
    sel_d       = blank ? SEG_OFF : ~(8'b1 << idx_q);
    seg_d       = blank ? SEG_OFF :
                  (act_mode_q == MODE_GFX) ? act_data_q[{idx_q, 3'b000} +: 8] :
                  (i_blank_lz && lz) ? SEG_OFF : {~act_dp_q[idx_q], hex_seg};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      pend_data_q <= '0;
      pend_mode_q <= MODE_TEXT;
      pend_dp_q   <= '0;
      act_data_q  <= '0;
      act_mode_q  <= MODE_TEXT;
      act_dp_q    <= '0;
      seg_q       <= SEG_OFF;
      sel_q       <= SEG_OFF;
      frame_q     <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      pend_data_q <= pend_data_d;
      pend_mode_q <= pend_mode_d;
      pend_dp_q   <= pend_dp_d;
      act_data_q  <= act_data_d;
      act_mode_q  <= act_mode_d;
      act_dp_q    <= act_dp_d;
      seg_q       <= seg_d;
      sel_q       <= sel_d;
      frame_q     <= frame_d;
    end
  end
  assign o_seg   = seg_q;
  assign o_sel   = sel_q;
  assign o_frame = frame_q;
endmodule
